// File: rtl/div_sequencer.sv
// Iterative radix-2 divider for RV32M div/divu/rem/remu.
// One quotient bit per CALC cycle, a FIX cycle applies result signs, and a
// one-cycle DONE pulse hands rd_data to execute. Divide-by-zero and signed
// overflow bypass the iteration and complete in one cycle.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd_data
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CW-1:0]     count_reg;
    logic [XLEN-1:0]   quo_reg;
    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   divisor_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              rem_sel_reg;
    logic [XLEN-1:0]   rd_data_reg;

    logic              accept;
    logic              is_signed;
    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_abs;
    logic [XLEN-1:0]   rs2_abs;
    logic              div_zero;
    logic              overflow;
    logic              fast_path;
    logic [XLEN-1:0]   fast_result;

    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // Operand decode: magnitudes, signs and RISC-V corner-case detection
    always_comb begin
        accept      = (state_reg == IDLE) && start && !flush;
        is_signed   = ~op[0];
        rs1_neg     = is_signed & rs1_data[XLEN-1];
        rs2_neg     = is_signed & rs2_data[XLEN-1];
        rs1_abs     = rs1_neg ? -rs1_data : rs1_data;
        rs2_abs     = rs2_neg ? -rs2_data : rs2_data;
        div_zero    = (rs2_data == '0);
        overflow    = is_signed && (rs1_data == MOST_NEG) && (rs2_data == '1);
        fast_path   = div_zero || overflow;
        if (div_zero) begin
            fast_result = op[1] ? rs1_data : '1;
        end else begin
            fast_result = op[1] ? '0 : MOST_NEG;
        end
    end

    // One restoring-division step plus the sign fix-up of the final result
    always_comb begin
        rem_shift = {rem_reg, quo_reg[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor_reg};
        if (!trial[XLEN]) begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo_reg[XLEN-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[XLEN-1:0];
            quo_step = {quo_reg[XLEN-2:0], 1'b0};
        end
        quo_fix = neg_q_reg ? -quo_reg : quo_reg;
        rem_fix = neg_r_reg ? -rem_reg : rem_reg;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush aborts any in-flight op except the DONE cycle
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = fast_path ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (count_reg == LAST_COUNT) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = flush ? IDLE : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy    = (state_reg != IDLE);
        done    = (state_reg == DONE);
        rd_data = rd_data_reg;
    end

    // Datapath: operand capture, iteration, and result commit on DONE entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg   <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            rem_sel_reg <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rem_sel_reg <= op[1];
                        neg_q_reg   <= rs1_neg ^ rs2_neg;
                        neg_r_reg   <= rs1_neg;
                        divisor_reg <= rs2_abs;
                        quo_reg     <= rs1_abs;
                        rem_reg     <= '0;
                        count_reg   <= '0;
                        if (fast_path) begin
                            rd_data_reg <= fast_result;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        rem_reg   <= rem_step;
                        quo_reg   <= quo_step;
                        count_reg <= count_reg + CW'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        rd_data_reg <= rem_sel_reg ? rem_fix : quo_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed-vector bench for div_sequencer: latency, results, fast path,
// flush, start-while-busy, back-to-back issue and asynchronous reset.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_result = '0;

    div_sequencer #(.XLEN(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // Issue one op, wait (bounded) for done, check latency, result and busy
    task automatic do_op(input string name, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit busy_ok;
        @(posedge clk);
        #1;
        op = o;
        rs1_data = a;
        rs2_data = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (1) begin
            @(negedge clk);
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1 || lat >= 100) break;
        end
        checks++;
        if (done !== 1'b1 || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (done=%b) expected %0d", name, lat, done, exp_lat);
        end
        checks++;
        if (rd_data !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, rd_data, exp_res);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy: dropped before done", name);
        end
        last_result = exp_res;
        $display("op %-24s a=%h b=%h -> rd=%h lat=%0d", name, a, b, rd_data, lat);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b rd=%h expected 0 0 0", busy, done, rd_data);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b done=%b expected 0 0", busy, done);
        end
        $display("reset released, idle");
    endtask

    task automatic test_divide();
        do_op("div 100/7",        2'b00, 32'd100,       32'd7,         32'd14,        34);
        do_op("rem 100/7",        2'b10, 32'd100,       32'd7,         32'd2,         34);
        do_op("divu 100/7",       2'b01, 32'd100,       32'd7,         32'd14,        34);
        do_op("div -7/2",         2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        do_op("rem -7/2",         2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        do_op("div 7/-2",         2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        do_op("rem 7/-2",         2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         34);
        do_op("div -7/-2",        2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         34);
        do_op("remu ffffffff/16", 2'b11, 32'hFFFF_FFFF, 32'd16,        32'd15,        34);
        do_op("divu ffffffff/16", 2'b01, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 34);
        do_op("divu 80000000/-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34);
        do_op("remu 80000000/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        do_op("div min/3",        2'b00, 32'h8000_0000, 32'd3,         32'hD555_5556, 34);
        do_op("rem min/3",        2'b10, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 34);
        do_op("div min/1",        2'b00, 32'h8000_0000, 32'd1,         32'h8000_0000, 34);
        do_op("div 0/5",          2'b00, 32'd0,         32'd5,         32'd0,         34);
    endtask

    task automatic test_fast_path();
        do_op("divu 5/0",         2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("rem 5/0",          2'b10, 32'd5,         32'd0,         32'd5,         1);
        do_op("div -5/0",         2'b00, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1);
        do_op("rem -5/0",         2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);
        do_op("div min/-1",       2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem min/-1",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        // done must drop and busy release the cycle after done
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_flush();
        int ndone;
        @(posedge clk);
        #1;
        op = 2'b00;
        rs1_data = 32'd1234;
        rs2_data = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // now in the first CALC cycle (count 0); advance to count 10
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_data !== last_result) begin
            errors++;
            $display("FAIL flush_calc: busy=%b done=%b rd=%h expected 0 0 %h", busy, done, rd_data, last_result);
        end
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL flush_no_done: got %0d dones expected 0", ndone);
        end
        $display("flush at count 10: op aborted, rd=%h", rd_data);
        do_op("div 9/3 after flush", 2'b00, 32'd9, 32'd3, 32'd3, 34);

        // flush together with start in IDLE: start ignored
        @(posedge clk);
        #1;
        op = 2'b00;
        rs1_data = 32'h8000_0000;
        rs2_data = 32'hFFFF_FFFF;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_data !== last_result) begin
            errors++;
            $display("FAIL flush_start_idle: busy=%b done=%b rd=%h expected 0 0 %h", busy, done, rd_data, last_result);
        end
        $display("start with flush in idle: ignored");

        // flush during the DONE cycle: done and result still delivered
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || rd_data !== 32'h8000_0000) begin
            errors++;
            $display("FAIL flush_in_done: done=%b rd=%h expected 1 80000000", done, rd_data);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_done_after: busy=%b done=%b expected 0 0", busy, done);
        end
        last_result = 32'h8000_0000;
        $display("flush in done cycle: done kept, rd=%h", rd_data);
    endtask

    task automatic test_back_to_back();
        int lat;
        int ndone;
        // second op issued the cycle after the first op's done
        do_op("b2b div 100/7", 2'b00, 32'd100, 32'd7, 32'd14, 34);
        do_op("b2b rem 100/7", 2'b10, 32'd100, 32'd7, 32'd2,  34);

        // start held high with changing operands for the whole op
        @(posedge clk);
        #1;
        op = 2'b00;
        rs1_data = 32'd200;
        rs2_data = 32'd9;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        ndone = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                ndone++;
                start = 1'b0;
                break;
            end
            if (lat >= 100) begin
                start = 1'b0;
                break;
            end
            rs1_data = $urandom;
            rs2_data = $urandom;
            op = 2'($urandom_range(0, 3));
        end
        checks++;
        if (lat != 34 || rd_data !== 32'd22) begin
            errors++;
            $display("FAIL start_spam_result: lat=%0d rd=%h expected 34 00000016", lat, rd_data);
        end
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_spam_done_count: dones=%0d busy=%b expected 1 0", ndone, busy);
        end
        last_result = 32'd22;
        $display("start held during op: dones=%0d rd=%h lat=%0d", ndone, rd_data, lat);
    endtask

    task automatic test_async_reset();
        int ndone;
        @(posedge clk);
        #1;
        op = 2'b00;
        rs1_data = 32'd100;
        rs2_data = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b rd=%h expected 0 0 0", busy, done, rd_data);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_no_done: dones=%0d rd=%h expected 0 0", ndone, rd_data);
        end
        $display("async reset mid-calc: op aborted");
        do_op("div 100/7 after reset", 2'b00, 32'd100, 32'd7, 32'd14, 34);
    endtask

    initial begin
        test_reset();
        test_divide();
        test_fast_path();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
